// File: rtl/mips_loader_pkg.sv
// Shared definitions for the MIPS boot-time program loader.
//   state_t    : loader FSM states, also exported on the top's dbg_state port
//   SYNC_BYTE  : frame start marker
//   ERR_*      : values driven on err_code
package mips_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_HI = 3'd1,
    CNT_LO = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_COUNT = 2'd1;
  localparam logic [1:0] ERR_CSUM  = 2'd2;

endpackage

// File: rtl/mips_byte_packer.sv
// Shifts bytes MSB-first into a DATA_WIDTH-bit word.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart at byte 0 with an all-zero word
//   shift_en   : shift in_byte into the word this cycle
//   in_byte    : byte to shift in
//   word       : registered word assembled so far
//   word_next  : value word takes if shift_en is high this cycle
//   word_full  : shift_en is high and this byte completes the word
//                (combinational, so the caller can act on the same edge)
module mips_byte_packer #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  shift_en,
  input  logic [7:0]            in_byte,
  output logic [DATA_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0] word_next,
  output logic                  word_full
);

  localparam int BPW = DATA_WIDTH / 8;
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BPW - 1);

  logic [IW-1:0] idx;

  generate
    if (DATA_WIDTH == 8) begin : g_one_byte
      assign word_next = in_byte;
    end else begin : g_multi_byte
      assign word_next = {word[DATA_WIDTH-9:0], in_byte};
    end
  endgenerate

  assign word_full = shift_en && (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      word <= '0;
    end else if (clr) begin
      idx  <= '0;
      word <= '0;
    end else if (shift_en) begin
      word <= word_next;
      idx  <= word_full ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/mips_prog_loader.sv
// Boot-time program loader: receives a framed byte stream
// (A5, count MSB/LSB, N words, checksum word; all MSB first), writes the
// words into instruction memory and releases the processor reset only after
// the XOR checksum of all words matches.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_data/in_valid  : byte stream input
//   in_ready          : loader can take a byte (low only in ERR)
//   err_clr           : pulse to leave ERR
//   imem_we/addr/wdata: one-cycle instruction-memory write
//   cpu_rst_n         : processor reset, released only in DONE
//   load_done         : high while in DONE
//   err_code          : ERR_NONE / ERR_COUNT / ERR_CSUM
//   dbg_state         : current FSM state
//
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready.
// in_valid may drop for any number of cycles; all state holds across gaps.
module mips_prog_loader
  import mips_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int PC_WIDTH   = 16,
  parameter int MEM_SIZE   = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  err_clr,
  output logic                  imem_we,
  output logic [PC_WIDTH-1:0]   imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_rst_n,
  output logic                  load_done,
  output logic [1:0]            err_code,
  output state_t                dbg_state
);

  // Count check is done at 17 bits so a 16-bit N is never truncated.
  localparam logic [16:0] MEM_SIZE_W = 17'(MEM_SIZE);

  state_t                state;
  state_t                state_nx;
  logic [7:0]            count_hi;
  logic [15:0]           words_left;
  logic [PC_WIDTH-1:0]   word_idx;
  logic [DATA_WIDTH-1:0] csum;
  logic                  csum_pend;   // checksum word captured, compare next cycle

  logic                  accept;
  logic                  is_sync;
  logic [15:0]           cnt_full;
  logic                  count_bad;
  logic                  pk_clr;
  logic                  pk_shift;
  logic [DATA_WIDTH-1:0] pk_word;
  logic [DATA_WIDTH-1:0] pk_word_next;
  logic                  pk_full;

  assign in_ready  = (state != ERR);
  assign accept    = in_valid && in_ready;
  assign is_sync   = accept && (in_data == SYNC_BYTE);
  assign cnt_full  = {count_hi, in_data};
  assign count_bad = (cnt_full == 16'd0) || ({1'b0, cnt_full} > MEM_SIZE_W);
  assign dbg_state = state;

  // A sync byte restarts the packer so stray partial words never leak into
  // a new frame. While a checksum compare is pending, further bytes are
  // accepted but dropped.
  assign pk_clr   = is_sync && ((state == IDLE) || (state == DONE));
  assign pk_shift = accept && ((state == DATA) || ((state == CSUM) && !csum_pend));

  mips_byte_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (pk_clr),
    .shift_en  (pk_shift),
    .in_byte   (in_data),
    .word      (pk_word),
    .word_next (pk_word_next),
    .word_full (pk_full)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (is_sync) state_nx = CNT_HI;
      CNT_HI:     if (accept) state_nx = CNT_LO;
      CNT_LO:     if (accept) state_nx = count_bad ? ERR : DATA;
      DATA:       if (pk_full && (words_left == 16'd1)) state_nx = CSUM;
      CSUM:       if (csum_pend) state_nx = (pk_word == csum) ? DONE : ERR;
      ERR:        if (err_clr) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count_hi   <= '0;
      words_left <= '0;
      word_idx   <= '0;
      csum       <= '0;
      csum_pend  <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst_n  <= 1'b0;
      load_done  <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      state     <= state_nx;
      imem_we   <= 1'b0;
      // Registered from the next state so both assert on the first DONE
      // cycle and drop on the cycle after a reload sync byte.
      cpu_rst_n <= (state_nx == DONE);
      load_done <= (state_nx == DONE);

      case (state)
        IDLE, DONE: begin
          if (is_sync) begin
            csum     <= '0;
            word_idx <= '0;
          end
        end
        CNT_HI: begin
          if (accept) count_hi <= in_data;
        end
        CNT_LO: begin
          if (accept) begin
            words_left <= cnt_full;
            if (count_bad) err_code <= ERR_COUNT;
          end
        end
        DATA: begin
          if (pk_full) begin
            imem_we    <= 1'b1;
            imem_addr  <= word_idx;
            imem_wdata <= pk_word_next;
            csum       <= csum ^ pk_word_next;
            words_left <= words_left - 16'd1;
            // Hold on the last word so the index stays below MEM_SIZE.
            if (words_left != 16'd1) word_idx <= word_idx + 1'b1;
          end
        end
        CSUM: begin
          if (csum_pend) begin
            csum_pend <= 1'b0;
            if (pk_word != csum) err_code <= ERR_CSUM;
          end else if (pk_full) begin
            csum_pend <= 1'b1;
          end
        end
        ERR: begin
          if (err_clr) err_code <= ERR_NONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
module tb_mips_prog_loader;
  import mips_loader_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        err_clr;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_rst_n;
  logic        load_done;
  logic [1:0]  err_code;
  state_t      dbg_state;

  int checks   = 0;
  int failures = 0;

  // Expected writes: {addr, data}
  logic [31:0] exp_q[$];
  logic [7:0]  frame_q[$];
  logic [15:0] wbuf[$];

  mips_prog_loader #(
    .DATA_WIDTH (16),
    .PC_WIDTH   (16),
    .MEM_SIZE   (256)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .err_clr    (err_clr),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .load_done  (load_done),
    .err_code   (err_code),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", imem_addr, imem_wdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("imem_write", {imem_addr, imem_wdata}, e);
      end
    end
  end

  // ---------------- reference model ----------------
  // Builds frame_q from n / wbuf and returns the expected err_code
  // (0 means the frame ends in DONE). Expected writes go into exp_q.
  task automatic model_frame(input logic [15:0] n, input logic [15:0] csum_flip,
                             output logic [1:0] exp_err);
    logic [15:0] x;
    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(n[15:8]);
    frame_q.push_back(n[7:0]);
    if (n == 0 || int'(n) > 256) begin
      exp_err = 2'd1;
    end else begin
      x = 16'h0;
      for (int i = 0; i < int'(n); i++) begin
        frame_q.push_back(wbuf[i][15:8]);
        frame_q.push_back(wbuf[i][7:0]);
        exp_q.push_back({16'(i), wbuf[i]});
        x = x ^ wbuf[i];
      end
      x = x ^ csum_flip;
      frame_q.push_back(x[15:8]);
      frame_q.push_back(x[7:0]);
      exp_err = (csum_flip != 0) ? 2'd2 : 2'd0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    waited = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stayed 0 for byte 0x%0h", b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  // gap < 0 means a random gap of 0..2 cycles per byte
  task automatic send_frame(input int gap);
    for (int i = 0; i < frame_q.size(); i++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      if (i == frame_q.size() - 1) g = 0;
      send_byte(frame_q[i], g);
    end
  endtask

  task automatic check_outcome(input string tag, input logic [1:0] exp_err);
    @(posedge clk);
    #1;
    check({tag, "_writes_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_err_code"}, 32'(err_code), 32'(exp_err));
    check({tag, "_load_done"}, 32'(load_done), 32'(exp_err == 2'd0));
    check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(exp_err == 2'd0));
    check({tag, "_in_ready"}, 32'(in_ready), 32'(exp_err == 2'd0));
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] e;
    logic [15:0] n;
    rst_n    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    err_clr  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic load: A5 00 02 12 34 AB CD B9 F9
    wbuf = '{16'h1234, 16'hABCD};
    model_frame(16'd2, 16'h0, e);
    send_frame(0);
    check("basic_not_done_yet", 32'(load_done), 32'd0);
    check_outcome("basic", e);

    // err_clr outside ERR is ignored
    pulse_err_clr();
    check("errclr_in_done", 32'(dbg_state), 32'(DONE));

    // Bad checksum B9 F8
    model_frame(16'd2, 16'h0001, e);
    send_frame(0);
    check_outcome("bad_csum", e);
    pulse_err_clr();
    check("clr_state", 32'(dbg_state), 32'(IDLE));
    check("clr_err_code", 32'(err_code), 32'd0);
    check("clr_in_ready", 32'(in_ready), 32'd1);

    // Bad counts: N=0 and N=257
    model_frame(16'd0, 16'h0, e);
    send_frame(0);
    check_outcome("count_zero", e);
    // in_valid with err_clr in ERR: byte must not be taken
    in_data  = 8'hA5;
    in_valid = 1'b1;
    err_clr  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    err_clr  = 1'b0;
    @(posedge clk);
    #1;
    check("clr_with_valid_state", 32'(dbg_state), 32'(IDLE));
    model_frame(16'd257, 16'h0, e);
    send_frame(0);
    check_outcome("count_257", e);
    pulse_err_clr();

    // Junk bytes then gapped basic frame
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h5A, 0);
    wbuf = '{16'h1234, 16'hABCD};
    model_frame(16'd2, 16'h0, e);
    send_frame(3);
    check_outcome("gapped", e);

    // Reload from DONE with N=1, word 0F0F
    wbuf = '{16'h0F0F};
    model_frame(16'd1, 16'h0, e);
    send_byte(frame_q[0], 0);
    check("reload_cpu_rst_drop", 32'(cpu_rst_n), 32'd0);
    check("reload_done_drop", 32'(load_done), 32'd0);
    void'(frame_q.pop_front());
    send_frame(0);
    check_outcome("reload", e);

    // Boundary: full memory N=256
    wbuf.delete();
    for (int i = 0; i < 256; i++) wbuf.push_back(16'($urandom));
    model_frame(16'd256, 16'h0, e);
    send_frame(0);
    check_outcome("full_mem", e);

    // Randomized frames
    for (int t = 0; t < 12; t++) begin
      wbuf.delete();
      n = 16'($urandom_range(1, 8));
      for (int i = 0; i < int'(n); i++) wbuf.push_back(16'($urandom));
      model_frame(n, ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 16'hFFFF)) : 16'h0, e);
      send_frame(-1);
      check_outcome("random", e);
      if (e != 2'd0) pulse_err_clr();
    end

    // Reset mid-DATA after two words written
    wbuf = '{16'h1111, 16'h2222, 16'h3333};
    model_frame(16'd3, 16'h0, e);
    for (int i = 0; i < 8; i++) send_byte(frame_q[i], 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    check("midrst_imem_we", 32'(imem_we), 32'd0);
    check("midrst_addr", 32'(imem_addr), 32'd0);
    check("midrst_wdata", 32'(imem_wdata), 32'd0);
    check("midrst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("midrst_load_done", 32'(load_done), 32'd0);
    check("midrst_err_code", 32'(err_code), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    exp_q.pop_back();
    check("midrst_writes_seen", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
